// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake and ALU operand/result bus between the sequencer and its environment.
// The slave modport is the sequencer side; the master modport is the issuer/ALU side.
interface alu_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) ();
    logic                  instr_valid;
    logic                  instr_ready;
    logic [4+3*ADDR_W-1:0] instr;
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [3:0]            alu_op;
    logic [DATA_W-1:0]     alu_res;

    modport master (
        output instr_valid, instr, alu_res,
        input  instr_ready, alu_a, alu_b, alu_op
    );

    modport slave (
        input  instr_valid, instr, alu_res,
        output instr_ready, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Operand-fetch / write-back sequencer for a combinational ALU, with its own register RAM.
// Define ALU_SEQ_ZF_EN to add a zero-flag output (zf) updated on retired non-error instructions.
module alu_seq_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_ctrl_if.slave     bus,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              err
`ifdef ALU_SEQ_ZF_EN
    ,
    output logic              zf
`endif
);
    localparam int unsigned Depth = 2**ADDR_W;
    localparam int unsigned IW    = 4 + 3*ADDR_W;
    localparam logic [3:0]  OpMin = 4'b0100;
    localparam logic [3:0]  OpMax = 4'b1101;
    localparam logic [3:0]  OpDiv = 4'b0111;

    typedef enum logic [1:0] {StIdle, StRd, StEx, StWb} state_e;

    state_e            state_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W-1:0] rb_q;
    logic [DATA_W-1:0] ram [Depth];

    logic              ex_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign bus.instr_ready = (state_q == StIdle);
    assign dbg_data        = ram[dbg_addr];

    always_comb begin
        ex_err = (bus.alu_op < OpMin) || (bus.alu_op > OpMax) ||
                 ((bus.alu_op == OpDiv) && (bus.alu_b == '0));
    end

    // Single write port: preload only while idle, write-back at the end of WB.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ld_addr;
        ram_wdata = ld_data;
        if (state_q == StIdle && ld_we) begin
            ram_we = 1'b1;
        end else if (state_q == StWb && !err) begin
            ram_we    = 1'b1;
            ram_waddr = rd_q;
            ram_wdata = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
            bus.alu_op <= '0;
            result     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef ALU_SEQ_ZF_EN
            zf         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.instr_valid) begin
                        op_q    <= bus.instr[IW-1 -: 4];
                        rd_q    <= bus.instr[3*ADDR_W-1 -: ADDR_W];
                        ra_q    <= bus.instr[2*ADDR_W-1 -: ADDR_W];
                        rb_q    <= bus.instr[ADDR_W-1:0];
                        state_q <= StRd;
                    end
                end
                StRd: begin
                    bus.alu_a  <= ram[ra_q];
                    bus.alu_b  <= ram[rb_q];
                    bus.alu_op <= op_q;
                    state_q    <= StEx;
                end
                StEx: begin
                    result  <= ex_err ? '0 : bus.alu_res;
                    done    <= 1'b1;
                    err     <= ex_err;
                    state_q <= StWb;
                end
                StWb: begin
`ifdef ALU_SEQ_ZF_EN
                    if (!err) begin
                        zf <= (result == '0);
                    end
`endif
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an instruction-level model of the sequencer and its register file.
module tb_alu_seq_ctrl;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          ld_we    = 1'b0;
    logic [AW-1:0] ld_addr  = '0;
    logic [DW-1:0] ld_data  = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;
    logic [DW-1:0] result;
    logic          done;
    logic          err;
`ifdef ALU_SEQ_ZF_EN
    logic          zf;
`endif

    alu_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .result   (result),
        .done     (done),
        .err      (err)
`ifdef ALU_SEQ_ZF_EN
        ,
        .zf       (zf)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'h4:    return a + b;
            4'h5:    return a - b;
            4'h6:    return a * b;
            4'h7:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'h8:    return a & b;
            4'h9:    return a | b;
            4'hA:    return ~(a & b);
            4'hB:    return ~(a | b);
            4'hC:    return a ^ b;
            4'hD:    return ~(a ^ b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit is_err(input logic [3:0] op, input logic [31:0] b);
        return (op < 4) || (op > 13) || (op == 4'h7 && b == 0);
    endfunction

    // The bench plays the combinational ALU; garbage on illegal/div0 must not reach result.
    initial bus.instr_valid = 1'b0;
    initial bus.instr       = '0;
    assign bus.alu_res = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Instruction-level model: everything about an instruction is decided at acceptance,
    // then revealed on the documented timeline (operands +1, result/done +2, write-back +3).
    logic [31:0] m_ram [16];
    logic [31:0] m_result = '0;
    logic [31:0] m_a = '0, m_b = '0, p_a = '0, p_b = '0, m_res = '0;
    logic [3:0]  m_op = '0, p_op = '0, m_rd = '0;
    bit          m_busy = 1'b0, m_e = 1'b0, m_zf = 1'b0;
    int          m_age = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] f_op, f_rd, f_ra, f_rb;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_result = '0;
            m_zf = 1'b0;
            m_a = '0;
            m_b = '0;
            m_op = '0;
        end else if (!m_busy) begin
            if (ld_we) m_ram[ld_addr] = ld_data;
            if (bus.instr_valid) begin
                {f_op, f_rd, f_ra, f_rb} = bus.instr;
                p_a   = m_ram[f_ra];
                p_b   = m_ram[f_rb];
                p_op  = f_op;
                m_e   = is_err(f_op, p_b);
                m_res = m_e ? 32'h0 : alu_f(f_op, p_a, p_b);
                m_rd  = f_rd;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_a = p_a;
                m_b = p_b;
                m_op = p_op;
            end
            if (m_age == 2) m_result = m_res;
            if (m_age == 3) begin
                if (!m_e) begin
                    m_ram[m_rd] = m_res;
                    m_zf = (m_res == 0);
                end
                m_busy = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n && cmp_en) begin
            chk("instr_ready", bus.instr_ready, !m_busy);
            chk("done", done, m_busy && m_age == 2);
            chk("err", err, m_busy && m_age == 2 && m_e);
            chk("result", result, m_result);
            chk("dbg_data", dbg_data, m_ram[dbg_addr]);
            chk("alu_a", bus.alu_a, m_a);
            chk("alu_b", bus.alu_b, m_b);
            chk("alu_op", bus.alu_op, m_op);
`ifdef ALU_SEQ_ZF_EN
            chk("zf", zf, m_zf);
`endif
        end
    end

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_we = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, output int gap);
        gap = 0;
        while (!bus.instr_ready && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        if (!bus.instr_ready) chk("issue_timeout", {31'b0, bus.instr_ready}, 32'd1);
        bus.instr = {op, rd, ra, rb};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        if (!done) chk("done_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic peek(input string name, input logic [3:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    initial begin
        int gap, cnt, ndone;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_alu_a", bus.alu_a, 32'h0);
        chk("rst_alu_b", bus.alu_b, 32'h0);
        chk("rst_alu_op", {28'b0, bus.alu_op}, 32'h0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        for (int i = 0; i < 16; i++) load(4'(i), $urandom);

        // Basic add with latency pin
        load(4'd1, 32'd7);
        load(4'd2, 32'd5);
        issue(4'h4, 4'd3, 4'd1, 4'd2, gap);
        wait_done(cnt);
        chk("add_latency", cnt, 32'd2);
        chk("add_result", result, 32'd12);
        chk("add_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        peek("add_r3", 4'd3, 32'd12);

        // Wrapping sub and truncating mul
        issue(4'h5, 4'd4, 4'd2, 4'd1, gap);
        wait_done(cnt);
        chk("sub_result", result, 32'hFFFF_FFFE);
        @(negedge clk);
        peek("sub_r4", 4'd4, 32'hFFFF_FFFE);
        load(4'd1, 32'h1_0000);
        load(4'd2, 32'h1_0000);
        issue(4'h6, 4'd5, 4'd1, 4'd2, gap);
        wait_done(cnt);
        chk("mul_result", result, 32'h0);
        chk("mul_err", {31'b0, err}, 32'd0);

        // Divide by zero and illegal opcode: error, no write
        @(negedge clk);
        load(4'd7, 32'd0);
        load(4'd8, 32'd123);
        load(4'd9, 32'h55);
        issue(4'h7, 4'd9, 4'd8, 4'd7, gap);
        wait_done(cnt);
        chk("div0_err", {31'b0, err}, 32'd1);
        chk("div0_result", result, 32'h0);
        @(negedge clk);
        peek("div0_r9", 4'd9, 32'h55);
        issue(4'h0, 4'd9, 4'd1, 4'd2, gap);
        wait_done(cnt);
        chk("illegal_err", {31'b0, err}, 32'd1);
        chk("illegal_result", result, 32'h0);
        @(negedge clk);
        peek("illegal_r9", 4'd9, 32'h55);

        // Back-to-back with dependency through R5
        load(4'd1, 32'd7);
        load(4'd2, 32'd5);
        issue(4'h4, 4'd5, 4'd1, 4'd2, gap);
        issue(4'hC, 4'd6, 4'd5, 4'd1, gap);
        chk("ready_gap", gap, 32'd3);
        wait_done(cnt);
        chk("b2b_result", result, 32'd11);
        @(negedge clk);
        peek("b2b_r6", 4'd6, 32'd11);

        // Load coinciding with accept is seen by RD
        ld_we = 1'b1;
        ld_addr = 4'd1;
        ld_data = 32'd9;
        bus.instr = {4'h4, 4'd3, 4'd1, 4'd2};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        ld_we = 1'b0;
        bus.instr_valid = 1'b0;
        wait_done(cnt);
        chk("ral_result", result, 32'd14);
        @(negedge clk);
        peek("ral_r3", 4'd3, 32'd14);

        // Load while busy is dropped
        issue(4'h4, 4'd10, 4'd1, 4'd2, gap);
        @(negedge clk);
        load(4'd1, 32'd99);
        wait_done(cnt);
        @(negedge clk);
        peek("busy_ld_r1", 4'd1, 32'd9);
        peek("busy_ld_r10", 4'd10, 32'd14);

        // Reset during EX
        load(4'd11, 32'h77);
        issue(4'h4, 4'd11, 4'd1, 4'd2, gap);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, bus.instr_ready}, 32'd1);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_mid_no_done", ndone, 32'd0);
        peek("rst_mid_r11", 4'd11, 32'h77);
        peek("rst_mid_r1", 4'd1, 32'd9);

`ifdef ALU_SEQ_ZF_EN
        issue(4'h5, 4'd12, 4'd1, 4'd1, gap);
        wait_done(cnt);
        @(negedge clk);
        chk("zf_set", {31'b0, zf}, 32'd1);
        issue(4'h4, 4'd12, 4'd1, 4'd2, gap);
        wait_done(cnt);
        @(negedge clk);
        chk("zf_clr", {31'b0, zf}, 32'd0);
`endif

        // Randomized traffic; the per-cycle compare does the checking
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                ld_we = 1'b0;
                bus.instr_valid = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            ld_we   = ($urandom_range(0, 3) == 0);
            ld_addr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) ld_data = 32'h0;
            else if ($urandom_range(0, 1) == 1) ld_data = $urandom;
            else ld_data = $urandom_range(0, 20);
            bus.instr_valid = $urandom_range(0, 1) == 1;
            bus.instr = 16'($urandom);
            dbg_addr = 4'($urandom);
            @(negedge clk);
        end
        ld_we = 1'b0;
        bus.instr_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
